instruction_fetch: RTL and testbench

//  Fetch stage feeding the decoder (instruction_decoder/rf path). Issues in-order word reads to a

---
 rtl/instruction_fetch_pkg.sv | 22 ++
 rtl/instruction_fetch_fifo.sv | 87 ++++++++
 rtl/instruction_fetch.sv | 191 +++++++++++++++++++
 tb/tb_instruction_fetch.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/instruction_fetch_pkg.sv
// ----------------------------------------------------------------------------
// instruction_fetch_pkg
// Shared definitions for the instruction fetch stage:
//   fetch_state_t : fetch FSM states (S_FETCH issues requests, S_DRAIN waits
//                   for stale responses to be thrown away)
//   ENTRY_W       : prefetch FIFO entry width, {pc[31:0], instr[31:0]}
//   cnt_width()   : width of counters that must hold 0..depth inclusive
// ----------------------------------------------------------------------------
package instruction_fetch_pkg;

    typedef enum logic [0:0] {
        S_FETCH = 1'b0,
        S_DRAIN = 1'b1
    } fetch_state_t;

    localparam int ENTRY_W = 64;

    function automatic int cnt_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/instruction_fetch_fifo.sv
// ----------------------------------------------------------------------------
// instruction_fetch_fifo
// Synchronous prefetch FIFO holding {pc, instr} entries for the fetch stage.
// The head entry is presented combinationally so decode sees it in the cycle
// after it was written. Flush wins over push/pop in the same cycle.
// Ports:
//   clk, reset      clock, asynchronous active-high reset
//   push, wdata     write an entry
//   pop             remove the head entry (ignored when empty)
//   flush           empty the FIFO
//   rdata           head entry
//   count           number of stored entries (0..DEPTH)
//   empty, full     status flags
// ----------------------------------------------------------------------------
module instruction_fetch_fifo
    import instruction_fetch_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = ENTRY_W,
    parameter int CW    = cnt_width(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic [CW-1:0]    count,
    output logic             empty,
    output logic             full
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_reg [DEPTH];
    logic [AW-1:0]    wr_ptr_reg;
    logic [AW-1:0]    rd_ptr_reg;
    logic [CW-1:0]    count_reg;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count_reg == '0);
    assign full    = (count_reg == CW'(DEPTH));
    assign count   = count_reg;
    assign rdata   = mem_reg[rd_ptr_reg];
    assign do_push = push && !flush;
    assign do_pop  = pop && !flush && !empty;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else if (flush) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= wr_ptr_reg + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_reg <= rd_ptr_reg + AW'(1);
            end
            if (do_push && !do_pop) begin
                count_reg <= count_reg + CW'(1);
            end else if (!do_push && do_pop) begin
                count_reg <= count_reg - CW'(1);
            end
        end
    end

    // Storage carries no reset; only the pointers define which entries are live.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_reg[wr_ptr_reg] <= wdata;
        end
    end

    // The issue credit in the parent keeps count+outstanding <= DEPTH, so a
    // response arriving into a full FIFO means the memory broke the protocol.
    fifo_no_overflow: assert property (@(posedge clk) disable iff (reset)
        !(do_push && full && !do_pop));

endmodule

// File: rtl/instruction_fetch.sv
// ----------------------------------------------------------------------------
// instruction_fetch
// Fetch stage: issues in-order word reads to a latency-tolerant instruction
// memory, buffers returned words with their PC in a prefetch FIFO and hands
// them to decode over valid/ready. Execute-stage redirects flush the stream;
// responses already in flight at the redirect are counted and discarded.
//
// Parameters:
//   RESET_PC    PC of the first fetch after reset
//   FIFO_DEPTH  prefetch entries (power of 2, >= 2); also caps outstanding reads
// Build option:
//   IF_BYTESWAP_EN  when defined, memory words are byte-reversed at FIFO write
//                   (memory holds big-endian words, decode wants RISC-V order)
// Ports:
//   clk, reset                        clock, asynchronous active-high reset
//   imem_req/imem_addr/imem_gnt       request channel; req+addr held until gnt
//   imem_rvalid/imem_rdata            in-order read responses
//   redirect_valid/redirect_pc        change of flow from execute
//   if_valid/if_pc/if_instr/if_ready  instruction handed to decode
// ----------------------------------------------------------------------------
module instruction_fetch
    import instruction_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        if_valid,
    output logic [31:0] if_pc,
    output logic [31:0] if_instr,
    input  logic        if_ready
);

    localparam int CW = cnt_width(FIFO_DEPTH);
    localparam int SW = CW + 1;

    fetch_state_t  state_reg, state_next;
    logic          req_reg, req_next;
    logic [31:0]   addr_reg, addr_next;
    logic [31:0]   fetch_pc_reg, fetch_pc_next;   // next address to request
    logic [31:0]   resp_pc_reg, resp_pc_next;     // PC of next kept response
    logic [CW-1:0] outstanding_reg, outstanding_next;
    logic [CW-1:0] discard_reg, discard_next;
    logic          stale_reg, stale_next;         // held request predates a redirect

    logic          granted;
    logic          keep_rsp;
    logic          pop;
    logic [31:0]   target;
    logic [31:0]   pc_base;
    logic [31:0]   word;
    logic [CW-1:0] fifo_count;
    logic [CW-1:0] fifo_count_next;
    logic [SW-1:0] credit_sum;
    logic          fifo_empty;
    logic          fifo_full;
    logic [ENTRY_W-1:0] fifo_rdata;
    logic          unused_bits;

`ifdef IF_BYTESWAP_EN
    for (genvar gi = 0; gi < 4; gi++) begin : g_swap
        assign word[8*gi +: 8] = imem_rdata[8*(3-gi) +: 8];
    end
`else
    assign word = imem_rdata;
`endif

    assign unused_bits = ^{redirect_pc[1:0], fifo_full};

    always_comb begin
        granted  = req_reg && imem_gnt;
        target   = {redirect_pc[31:2], 2'b00};
        // A response in a redirect cycle is stale even when discard is zero.
        keep_rsp = imem_rvalid && (discard_reg == '0) && !redirect_valid;
        pop      = if_valid && if_ready && !redirect_valid;

        if (redirect_valid) begin
            fifo_count_next = '0;
        end else begin
            fifo_count_next = fifo_count + CW'(keep_rsp) - CW'(pop);
        end

        outstanding_next = outstanding_reg + CW'(granted) - CW'(imem_rvalid);

        // On redirect everything still in flight (including this cycle's grant)
        // is stale. Otherwise drop one per discarded response and add one when a
        // request held across an earlier redirect is finally granted.
        if (redirect_valid) begin
            discard_next = outstanding_next;
        end else begin
            discard_next = discard_reg;
            if (imem_rvalid && (discard_reg != '0)) begin
                discard_next = discard_next - CW'(1);
            end
            if (granted && stale_reg) begin
                discard_next = discard_next + CW'(1);
            end
        end

        if (req_reg && !imem_gnt) begin
            stale_next = stale_reg || redirect_valid;
        end else begin
            stale_next = 1'b0;
        end

        state_next = state_reg;
        case (state_reg)
            S_FETCH: if (redirect_valid && ((discard_next != '0) || stale_next)) state_next = S_DRAIN;
            S_DRAIN: if ((discard_next == '0) && !stale_next) state_next = S_FETCH;
            default: state_next = S_FETCH;
        endcase

        if (redirect_valid) begin
            resp_pc_next = target;
        end else if (keep_rsp) begin
            resp_pc_next = resp_pc_reg + 32'd4;
        end else begin
            resp_pc_next = resp_pc_reg;
        end

        // Credit counts FIFO entries plus reads in flight, both as they will be
        // after this edge, so a new request always has a FIFO slot reserved.
        pc_base       = redirect_valid ? target : fetch_pc_reg;
        credit_sum    = {1'b0, fifo_count_next} + {1'b0, outstanding_next};
        req_next      = 1'b0;
        addr_next     = addr_reg;
        fetch_pc_next = pc_base;
        if (req_reg && !imem_gnt) begin
            // Ungranted request keeps its address, even across a redirect.
            req_next = 1'b1;
        end else if ((state_next == S_FETCH) && (credit_sum < SW'(FIFO_DEPTH))) begin
            req_next      = 1'b1;
            addr_next     = pc_base;
            fetch_pc_next = pc_base + 32'd4;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg       <= S_FETCH;
            req_reg         <= 1'b0;
            addr_reg        <= RESET_PC;
            fetch_pc_reg    <= RESET_PC;
            resp_pc_reg     <= RESET_PC;
            outstanding_reg <= '0;
            discard_reg     <= '0;
            stale_reg       <= 1'b0;
        end else begin
            state_reg       <= state_next;
            req_reg         <= req_next;
            addr_reg        <= addr_next;
            fetch_pc_reg    <= fetch_pc_next;
            resp_pc_reg     <= resp_pc_next;
            outstanding_reg <= outstanding_next;
            discard_reg     <= discard_next;
            stale_reg       <= stale_next;
        end
    end

    instruction_fetch_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (ENTRY_W),
        .CW    (CW)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (keep_rsp),
        .pop   (pop),
        .flush (redirect_valid),
        .wdata ({resp_pc_reg, word}),
        .rdata (fifo_rdata),
        .count (fifo_count),
        .empty (fifo_empty),
        .full  (fifo_full)
    );

    assign imem_req  = req_reg;
    assign imem_addr = addr_reg;
    assign if_valid  = !fifo_empty;
    assign if_pc     = fifo_rdata[63:32];
    assign if_instr  = fifo_rdata[31:0];

endmodule

// File: tb/tb_instruction_fetch.sv
// ----------------------------------------------------------------------------
// tb_instruction_fetch
// Drives instruction_fetch with a behavioural instruction memory and checks the
// instruction stream seen by decode against an architectural model: starting
// at RESET_PC, PCs advance by 4 and restart at each redirect target; every PC
// is delivered exactly once with the memory word stored at that address.
// Inputs are driven 1 time unit after posedge; outputs are sampled at negedge.
// ----------------------------------------------------------------------------
module tb_instruction_fetch;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
`ifdef IF_BYTESWAP_EN
    localparam logic [31:0] WORD_200_EXP = 32'h0000_0013;
`else
    localparam logic [31:0] WORD_200_EXP = 32'h1300_0000;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        if_valid;
    logic [31:0] if_pc;
    logic [31:0] if_instr;
    logic        if_ready;

    always #5 clk = ~clk;

    instruction_fetch #(
        .RESET_PC   (RESET_PC),
        .FIFO_DEPTH (4)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_gnt       (imem_gnt),
        .imem_rvalid    (imem_rvalid),
        .imem_rdata     (imem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .if_valid       (if_valid),
        .if_pc          (if_pc),
        .if_instr       (if_instr),
        .if_ready       (if_ready)
    );

    typedef struct {
        logic [31:0] addr;
        int          due;
    } rsp_t;

    rsp_t        pend[$];        // granted reads awaiting their response
    logic [31:0] exp_q[$];       // expected PCs at the decode interface
    logic [31:0] gen_pc;
    int          cyc      = 0;
    int          last_due = 0;
    int          lat_lo   = 1;
    int          lat_hi   = 1;
    int          n_checks = 0;
    int          n_pass   = 0;
    int          hs_count = 0;
    int          gap_cnt  = 0;
    bit          gap_watch = 0;
    bit          seen_v   = 0;
    bit          chk_flush = 0;

    // memory-side address model
    logic [31:0] next_addr = RESET_PC;
    logic [31:0] after_tgt = '0;
    logic [31:0] held_addr = '0;
    bit          stale_hold = 0;
    bit          held_chk   = 0;
    int          mem_due;
    logic [31:0] exp_pc;
    int          hs_mark;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h0000_0200) return 32'h1300_0000;
        return a ^ {a[15:0], a[31:16]} ^ 32'h0BAD_F00D;
    endfunction

    function automatic logic [31:0] exp_instr(input logic [31:0] a);
        logic [31:0] w;
        w = mem_word(a);
`ifdef IF_BYTESWAP_EN
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
`else
        return w;
`endif
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, req, cyc);
    endtask

    // One clock of stimulus; also presents memory responses that are due.
    task automatic drive(input bit g, input bit rdy, input bit rv, input logic [31:0] tgt);
        @(posedge clk);
        #1;
        cyc++;
        imem_gnt       = g;
        if_ready       = rdy;
        redirect_valid = rv;
        redirect_pc    = tgt;
        if (rv) begin
            exp_q.delete();
            gen_pc = {tgt[31:2], 2'b00};
            $display("redirect cycle %0d target %h", cyc, tgt);
        end
        while (exp_q.size() < 16) begin
            exp_q.push_back(gen_pc);
            gen_pc = gen_pc + 32'd4;
        end
        if (pend.size() > 0 && pend[0].due <= cyc) begin
            imem_rvalid = 1'b1;
            imem_rdata  = mem_word(pend[0].addr);
            void'(pend.pop_front());
        end else begin
            imem_rvalid = 1'b0;
            imem_rdata  = $urandom;
        end
    endtask

    // Memory model: records grants, schedules in-order responses, and checks
    // that requested addresses follow the architectural fetch sequence.
    always @(negedge clk) begin
        if (!reset) begin
            if (held_chk) begin
                check("held_req", {31'd0, imem_req}, 32'd1);
                check("held_addr", imem_addr, held_addr);
            end
            held_chk = 0;
            if (imem_req && imem_gnt) begin
                check("grant_addr", imem_addr, next_addr);
                mem_due = cyc + int'($urandom_range(lat_hi, lat_lo));
                if (mem_due <= last_due) mem_due = last_due + 1;
                last_due = mem_due;
                pend.push_back('{addr: imem_addr, due: mem_due});
                if (stale_hold) begin
                    next_addr  = after_tgt;
                    stale_hold = 0;
                end else begin
                    next_addr = next_addr + 32'd4;
                end
            end else if (imem_req) begin
                held_chk  = 1;
                held_addr = imem_addr;
            end
            if (redirect_valid) begin
                if (imem_req && !imem_gnt) begin
                    stale_hold = 1;
                    after_tgt  = {redirect_pc[31:2], 2'b00};
                end else begin
                    next_addr = {redirect_pc[31:2], 2'b00};
                end
            end
        end
    end

    // Scoreboard monitor: compares every consumed instruction to the model.
    always @(negedge clk) begin
        if (!reset) begin
            if (chk_flush) check("flush_valid", {31'd0, if_valid}, 32'd0);
            chk_flush = redirect_valid;
            if (if_valid && if_ready && !redirect_valid) begin
                hs_count++;
                if (exp_q.size() == 0) begin
                    check("sb_empty", if_pc, 32'hxxxx_xxxx);
                end else begin
                    exp_pc = exp_q.pop_front();
                    $display("txn %0d cycle %0d pc=%h instr=%h", hs_count, cyc, if_pc, if_instr);
                    check("if_pc", if_pc, exp_pc);
                    check("if_instr", if_instr, exp_instr(exp_pc));
                    if (exp_pc == 32'h0000_0200) check("word_200", if_instr, WORD_200_EXP);
                end
            end
            if (gap_watch) begin
                if (if_valid) seen_v = 1;
                else if (seen_v) gap_cnt++;
            end
        end
    end

    initial begin
        reset = 1'b1;
        imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
        redirect_valid = 1'b0; redirect_pc = '0; if_ready = 1'b0;
        gen_pc = RESET_PC;
        repeat (3) drive(0, 0, 0, 32'd0);
        check("rst_req", {31'd0, imem_req}, 32'd0);
        check("rst_valid", {31'd0, if_valid}, 32'd0);
        check("rst_addr", imem_addr, RESET_PC);
        reset = 1'b0;

        // zero-wait memory, decode always ready: unbroken stream
        gap_watch = 1;
        repeat (40) drive(1, 1, 0, 32'd0);
        gap_watch = 0;
        check("gap_zero_wait", gap_cnt, 32'd0);
        check("stream_started", {31'd0, seen_v}, 32'd1);

        // backpressure: fetch must stop once the FIFO is full, resume gap-free
        repeat (10) drive(1, 0, 0, 32'd0);
        check("stall_req_low", {31'd0, imem_req}, 32'd0);
        check("stall_valid", {31'd0, if_valid}, 32'd1);
        gap_cnt = 0; seen_v = 0; gap_watch = 1;
        repeat (20) drive(1, 1, 0, 32'd0);
        gap_watch = 0;
        check("gap_release", gap_cnt, 32'd0);

        // exactly FIFO_DEPTH entries are buffered during a stall
        repeat (10) drive(1, 0, 0, 32'd0);
        hs_mark = hs_count;
        repeat (8) drive(0, 1, 0, 32'd0);
        check("buffered_entries", hs_count - hs_mark, 32'd4);
        repeat (10) drive(1, 1, 0, 32'd0);

        // 3-cycle latency with redirect to an unaligned target
        lat_lo = 3; lat_hi = 3;
        repeat (12) drive(1, 1, 0, 32'd0);
        drive(1, 1, 1, 32'h0000_0103);
        repeat (25) drive(1, 1, 0, 32'd0);

        // zero-wait redirect colliding with rvalid and a pop
        lat_lo = 1; lat_hi = 1;
        repeat (10) drive(1, 1, 0, 32'd0);
        drive(1, 1, 1, 32'h0000_0200);
        repeat (15) drive(1, 1, 0, 32'd0);

        // redirect while a request waits for grant
        repeat (2) drive(0, 1, 0, 32'd0);
        drive(0, 1, 1, 32'h0000_0400);
        drive(0, 1, 0, 32'd0);
        repeat (20) drive(1, 1, 0, 32'd0);

        // PC wrap-around
        drive(1, 1, 1, 32'hFFFF_FFF8);
        repeat (20) drive(1, 1, 0, 32'd0);

        // randomized traffic
        lat_lo = 1; lat_hi = 4;
        repeat (1500) begin
            drive($urandom_range(99, 0) < 70, $urandom_range(99, 0) < 75,
                  $urandom_range(99, 0) < 3, $urandom);
        end
        lat_lo = 1; lat_hi = 1;
        repeat (12) drive(1, 1, 0, 32'd0);
        check("progress", (hs_count > 300) ? 32'd1 : 32'd0, 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
